// File: rtl/mac_package.sv
// Shared types and default constants for the panda memory loader: FSM state
// encoding, the NULL memory select and the default parameter values.
package mac_package;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        REQ       = 3'd2,
        STREAM    = 3'd3,
        NEXT      = 3'd4,
        TERMINATE = 3'd5
    } state_loader_t;

    localparam int unsigned DEF_NB_MEM          = 7;
    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_AMEM_ADDR_WIDTH = 16;
    localparam int unsigned DEF_LEN_WIDTH       = 16;
    localparam int unsigned DEF_SEL_WIDTH       = $clog2(DEF_NB_MEM + 1);

    // One past the last region index means "no memory selected".
    localparam logic [DEF_SEL_WIDTH-1:0] NULL_SEL = DEF_SEL_WIDTH'(DEF_NB_MEM);

endpackage

// File: rtl/panda_mem_addr_cnt.sv
// Per-region write-address and beat counter: loaded with the region base and
// length, steps once per accepted beat and flags the final beat.
module panda_mem_addr_cnt
    import mac_package::*;
#(
    parameter int unsigned AMEM_ADDR_WIDTH = DEF_AMEM_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH       = DEF_LEN_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       load_i,
    input  logic [AMEM_ADDR_WIDTH-1:0] base_i,
    input  logic [LEN_WIDTH-1:0]       len_i,
    input  logic                       inc_i,
    output logic [AMEM_ADDR_WIDTH-1:0] addr_o,
    output logic                       last_o
);

    logic [AMEM_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]       beat_q;
    logic [LEN_WIDTH-1:0]       len_q;

    // Address wraps naturally at the address width; beat never exceeds len-1.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            addr_q <= {AMEM_ADDR_WIDTH{1'b0}};
            beat_q <= {LEN_WIDTH{1'b0}};
            len_q  <= {LEN_WIDTH{1'b0}};
        end else if (load_i) begin
            addr_q <= base_i;
            beat_q <= {LEN_WIDTH{1'b0}};
            len_q  <= len_i;
        end else if (inc_i) begin
            addr_q <= addr_q + AMEM_ADDR_WIDTH'(1);
            beat_q <= beat_q + LEN_WIDTH'(1);
        end
    end

    assign addr_o = addr_q;
    assign last_o = (beat_q == (len_q - LEN_WIDTH'(1)));

endmodule

// File: rtl/panda_mem_loader.sv
// Walks the enabled regions in index order, requests each from the streamer
// and writes every accepted stream beat into the region's accelerator memory.
module panda_mem_loader
    import mac_package::*;
#(
    parameter int unsigned  NB_MEM          = DEF_NB_MEM,
    parameter int unsigned  DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned  AMEM_ADDR_WIDTH = DEF_AMEM_ADDR_WIDTH,
    parameter int unsigned  LEN_WIDTH       = DEF_LEN_WIDTH,
    localparam int unsigned SEL_WIDTH       = $clog2(NB_MEM + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    start_i,
    input  logic                                    clear_i,
    input  logic [NB_MEM-1:0]                       cfg_en_i,
    input  logic [NB_MEM-1:0][31:0]                 cfg_dmem_addr_i,
    input  logic [NB_MEM-1:0][LEN_WIDTH-1:0]        cfg_len_i,
    input  logic [NB_MEM-1:0][AMEM_ADDR_WIDTH-1:0]  cfg_amem_addr_i,
    output logic                                    src_req_start_o,
    input  logic                                    src_ready_start_i,
    output logic [31:0]                             src_addr_o,
    output logic [LEN_WIDTH-1:0]                    src_len_o,
    input  logic [DATA_WIDTH-1:0]                   data_i,
    input  logic                                    valid_i,
    output logic                                    ready_o,
    output logic [SEL_WIDTH-1:0]                    mem_sel_o,
    output logic                                    mem_wr_en_o,
    output logic [AMEM_ADDR_WIDTH-1:0]              mem_addr_o,
    output logic [DATA_WIDTH-1:0]                   mem_wdata_o,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic [SEL_WIDTH-1:0]                    region_o
);

    localparam int unsigned          IDX_WIDTH = (NB_MEM > 1) ? $clog2(NB_MEM) : 1;
    localparam logic [SEL_WIDTH-1:0] SEL_NULL  = SEL_WIDTH'(NB_MEM);
    localparam logic [SEL_WIDTH-1:0] SEL_LAST  = SEL_WIDTH'(NB_MEM - 1);

    state_loader_t                          state_q;
    logic [SEL_WIDTH-1:0]                   idx_q;
    logic [NB_MEM-1:0]                      en_q;
    logic [NB_MEM-1:0][31:0]                dmem_q;
    logic [NB_MEM-1:0][LEN_WIDTH-1:0]       len_q;
    logic [NB_MEM-1:0][AMEM_ADDR_WIDTH-1:0] amem_q;

    logic                       req_q;
    logic [31:0]                src_addr_q;
    logic [LEN_WIDTH-1:0]       src_len_q;
    logic                       ready_q;
    logic                       wr_en_q;
    logic [SEL_WIDTH-1:0]       sel_q;
    logic [AMEM_ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic                       busy_q;
    logic                       done_q;

    logic [IDX_WIDTH-1:0]       idx_s;
    logic                       hit_s;
    logic                       last_idx_s;
    logic                       xfer_s;
    logic                       load_s;
    logic [AMEM_ADDR_WIDTH-1:0] cnt_addr_s;
    logic                       cnt_last_s;

    assign idx_s      = idx_q[IDX_WIDTH-1:0];
    assign hit_s      = en_q[idx_s] && (len_q[idx_s] != {LEN_WIDTH{1'b0}});
    assign last_idx_s = (idx_q == SEL_LAST);
    // A beat is only taken when not aborting in the same cycle.
    assign xfer_s     = valid_i && ready_q && !clear_i;
    assign load_s     = (state_q == SELECT) && hit_s && !clear_i;

    panda_mem_addr_cnt #(
        .AMEM_ADDR_WIDTH (AMEM_ADDR_WIDTH),
        .LEN_WIDTH       (LEN_WIDTH)
    ) u_addr_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .load_i  (load_s),
        .base_i  (amem_q[idx_s]),
        .len_i   (len_q[idx_s]),
        .inc_i   (xfer_s),
        .addr_o  (cnt_addr_s),
        .last_o  (cnt_last_s)
    );

    // Sequencer and registered outputs; the write port follows transfers independently of state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= {SEL_WIDTH{1'b0}};
            en_q       <= {NB_MEM{1'b0}};
            dmem_q     <= '0;
            len_q      <= '0;
            amem_q     <= '0;
            req_q      <= 1'b0;
            src_addr_q <= 32'd0;
            src_len_q  <= {LEN_WIDTH{1'b0}};
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            sel_q      <= SEL_NULL;
            waddr_q    <= {AMEM_ADDR_WIDTH{1'b0}};
            wdata_q    <= {DATA_WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q <= xfer_s;
            sel_q   <= xfer_s ? idx_q : SEL_NULL;
            if (xfer_s) begin
                waddr_q <= cnt_addr_s;
                wdata_q <= data_i;
            end
            done_q <= 1'b0;
            if (clear_i) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            en_q    <= cfg_en_i;
                            dmem_q  <= cfg_dmem_addr_i;
                            len_q   <= cfg_len_i;
                            amem_q  <= cfg_amem_addr_i;
                            idx_q   <= {SEL_WIDTH{1'b0}};
                            busy_q  <= 1'b1;
                            state_q <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (hit_s) begin
                            req_q      <= 1'b1;
                            src_addr_q <= dmem_q[idx_s];
                            src_len_q  <= len_q[idx_s];
                            state_q    <= REQ;
                        end else if (last_idx_s) begin
                            done_q  <= 1'b1;
                            state_q <= TERMINATE;
                        end else begin
                            idx_q <= idx_q + SEL_WIDTH'(1);
                        end
                    end
                    REQ: begin
                        if (src_ready_start_i) begin
                            req_q   <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (xfer_s && cnt_last_s) begin
                            ready_q <= 1'b0;
                            state_q <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (last_idx_s) begin
                            done_q  <= 1'b1;
                            state_q <= TERMINATE;
                        end else begin
                            idx_q   <= idx_q + SEL_WIDTH'(1);
                            state_q <= SELECT;
                        end
                    end
                    TERMINATE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        req_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign src_req_start_o = req_q;
    assign src_addr_o      = src_addr_q;
    assign src_len_o       = src_len_q;
    assign ready_o         = ready_q;
    assign mem_wr_en_o     = wr_en_q;
    assign mem_sel_o       = sel_q;
    assign mem_addr_o      = waddr_q;
    assign mem_wdata_o     = wdata_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign region_o        = idx_q;

endmodule

// File: tb/tb_panda_mem_loader.sv
// Randomized and directed bench for panda_mem_loader against a region-list
// model of the expected write stream, streamer requests, busy and done.
module tb_panda_mem_loader;

    localparam int NB = 7;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int SW = 3;
    localparam logic [SW-1:0] SEL_NULL = 3'd7;

    logic                   clk = 1'b0;
    logic                   rst_i, start_i, clear_i;
    logic [NB-1:0]          cfg_en_i;
    logic [NB-1:0][31:0]    cfg_dmem_addr_i;
    logic [NB-1:0][LW-1:0]  cfg_len_i;
    logic [NB-1:0][AW-1:0]  cfg_amem_addr_i;
    logic                   src_req_start_o, src_ready_start_i;
    logic [31:0]            src_addr_o;
    logic [LW-1:0]          src_len_o;
    logic [DW-1:0]          data_i;
    logic                   valid_i, ready_o;
    logic [SW-1:0]          mem_sel_o, region_o;
    logic                   mem_wr_en_o, busy_o, done_o;
    logic [AW-1:0]          mem_addr_o;
    logic [DW-1:0]          mem_wdata_o;

    always #5 clk = ~clk;

    panda_mem_loader #(.NB_MEM(NB), .DATA_WIDTH(DW), .AMEM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
        .cfg_en_i(cfg_en_i), .cfg_dmem_addr_i(cfg_dmem_addr_i), .cfg_len_i(cfg_len_i),
        .cfg_amem_addr_i(cfg_amem_addr_i), .src_req_start_o(src_req_start_o),
        .src_ready_start_i(src_ready_start_i), .src_addr_o(src_addr_o), .src_len_o(src_len_o),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .mem_sel_o(mem_sel_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .region_o(region_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: ordered list of regions to load, progress through it, pending write.
    bit              m_busy = 1'b0, m_ready = 1'b0;
    int              m_ptr = 0, m_beat = 0, m_rem = 0;
    int              r_sel[$], r_len[$];
    logic [31:0]     r_dmem[$];
    logic [AW-1:0]   r_base[$];
    bit              pend = 1'b0;
    logic [SW-1:0]   p_sel;
    logic [AW-1:0]   p_addr;
    logic [DW-1:0]   p_data;
    int              done_cnt = 0, req_cycles = 0;
    bit              chk_en = 1'b0;
    typedef struct { int sel; int addr; } wr_t;
    wr_t             wlog[$];

    // Stimulus knobs
    int  vmode = 0;      // 0 always, 1 toggle, 2 random, 3 manual
    bit  man_valid = 1'b0;
    int  rd_delay = 0;

    task automatic model_flush();
        m_busy = 1'b0; m_ready = 1'b0; m_ptr = 0;
        r_sel.delete(); r_len.delete(); r_dmem.delete(); r_base.delete();
    endtask

    // Compare process: outputs of this cycle vs model, then advance the model.
    initial begin
        bit ok, xfer;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (pend) begin
                    chk("wr_en", mem_wr_en_o, 1);
                    chk("wr_sel", mem_sel_o, p_sel);
                    chk("wr_addr", mem_addr_o, p_addr);
                    chk("wr_data", mem_wdata_o, p_data);
                end else begin
                    chk("wr_idle_en", mem_wr_en_o, 0);
                    chk("wr_idle_sel", mem_sel_o, SEL_NULL);
                end
                chk("busy", busy_o, m_busy);
                chk("ready", ready_o, m_ready);
                if (src_req_start_o) begin
                    req_cycles++;
                    ok = m_busy && !m_ready && (m_ptr < r_sel.size());
                    chk("req_expected", ok, 1);
                    if (ok) begin
                        chk("req_addr", src_addr_o, r_dmem[m_ptr]);
                        chk("req_len", src_len_o, r_len[m_ptr]);
                        chk("req_region", region_o, r_sel[m_ptr]);
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    chk("done_expected", m_busy && !m_ready && !pend && (m_ptr == r_sel.size()), 1);
                end
            end
            if (mem_wr_en_o === 1'b1) wlog.push_back('{sel: int'(mem_sel_o), addr: int'(mem_addr_o)});
            xfer = valid_i && m_ready && !clear_i;
            if (rst_i) begin
                pend = 1'b0;
                model_flush();
            end else begin
                pend = xfer;
                if (xfer) begin
                    p_sel  = SW'(r_sel[m_ptr]);
                    p_addr = r_base[m_ptr] + AW'(m_beat);
                    p_data = data_i;
                    m_beat++;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_ready = 1'b0;
                        m_ptr++;
                    end
                end
                if (clear_i) begin
                    model_flush();
                end else if (done_o && m_busy) begin
                    m_busy = 1'b0;
                end else if (!m_busy && start_i) begin
                    model_flush();
                    m_busy = 1'b1;
                    for (int i = 0; i < NB; i++) begin
                        if (cfg_en_i[i] && cfg_len_i[i] != 0) begin
                            r_sel.push_back(i);
                            r_len.push_back(int'(cfg_len_i[i]));
                            r_dmem.push_back(cfg_dmem_addr_i[i]);
                            r_base.push_back(cfg_amem_addr_i[i]);
                        end
                    end
                end else if (src_req_start_o && src_ready_start_i && m_busy && !m_ready && m_ptr < r_sel.size()) begin
                    m_ready = 1'b1;
                    m_beat  = 0;
                    m_rem   = r_len[m_ptr];
                end
            end
        end
    end

    // Stream source: fresh data every cycle, valid per selected pattern.
    initial begin
        valid_i = 1'b0;
        data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            data_i = $urandom;
            case (vmode)
                0: valid_i = 1'b1;
                1: valid_i = ~valid_i;
                2: valid_i = 1'($urandom_range(0, 1));
                default: valid_i = man_valid;
            endcase
        end
    end

    // Streamer start handshake: accept after rd_delay cycles of request.
    initial begin
        int cnt;
        cnt = 0;
        src_ready_start_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (src_req_start_o && !src_ready_start_i) begin
                if (cnt >= rd_delay) begin
                    src_ready_start_i = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                src_ready_start_i = 1'b0;
                cnt = 0;
            end
        end
    end

    task automatic cfg_clear();
        cfg_en_i = '0; cfg_dmem_addr_i = '0; cfg_len_i = '0; cfg_amem_addr_i = '0;
    endtask

    task automatic cfg_set(input int i, input int len, input int base, input logic [31:0] dmem);
        cfg_en_i[i] = 1'b1;
        cfg_len_i[i] = LW'(len);
        cfg_amem_addr_i[i] = AW'(base);
        cfg_dmem_addr_i[i] = dmem;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    // Start a run, scramble cfg afterwards, wait (bounded) for exactly one done.
    task automatic run(input int timeout, input bit extra_start, output int cycles);
        int d0;
        wlog.delete();
        d0 = done_cnt;
        cycles = 0;
        pulse_start();
        cfg_en_i = NB'($urandom); cfg_len_i = {$urandom, $urandom, $urandom, $urandom};
        cfg_amem_addr_i = {$urandom, $urandom, $urandom, $urandom};
        if (extra_start) begin
            @(posedge clk); cycles++;
            @(posedge clk); cycles++;
            #1 start_i = 1'b1;
            @(posedge clk); cycles++;
            #1 start_i = 1'b0;
        end
        for (int i = 0; i < timeout && done_cnt == d0; i++) begin
            @(posedge clk);
            cycles++;
        end
        chk("done_once", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
        chk("done_count_after", done_cnt - d0, 1);
        chk("idle_after_done", busy_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, src_req_start_o, 0);
        chk({tag, "_saddr"}, src_addr_o, 0);
        chk({tag, "_slen"}, src_len_o, 0);
        chk({tag, "_ready"}, ready_o, 0);
        chk({tag, "_sel"}, mem_sel_o, SEL_NULL);
        chk({tag, "_wr"}, mem_wr_en_o, 0);
        chk({tag, "_waddr"}, mem_addr_o, 0);
        chk({tag, "_wdata"}, mem_wdata_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_region"}, region_o, 0);
    endtask

    initial begin
        int cyc, d0, exp_total;
        int e_sel[5];
        int e_addr[5];
        int w_addr[4];
        rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0;
        cfg_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_i = 1'b0; chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // Two regions plus an enabled zero-length region that must be skipped
        cfg_clear();
        cfg_set(0, 3, 'h10, 32'h1000_0000);
        cfg_set(2, 0, 'h50, 32'h2000_0000);
        cfg_set(4, 2, 'h20, 32'h4000_0040);
        cfg_len_i[5] = 16'd9;
        vmode = 0; rd_delay = 0;
        run(200, 1'b0, cyc);
        e_sel  = '{0, 0, 0, 4, 4};
        e_addr = '{'h10, 'h11, 'h12, 'h20, 'h21};
        chk("two_region_writes", wlog.size(), 5);
        if (wlog.size() == 5)
            for (int i = 0; i < 5; i++) begin
                chk("two_region_sel", wlog[i].sel, e_sel[i]);
                chk("two_region_addr", wlog[i].addr, e_addr[i]);
            end

        // Nothing enabled
        cfg_clear();
        cfg_len_i = {NB{16'd5}};
        run(50, 1'b0, cyc);
        chk("all_off_latency_ok", cyc <= NB + 2, 1);
        chk("all_off_writes", wlog.size(), 0);

        // Toggling valid
        cfg_clear();
        cfg_set(1, 4, 'h100, 32'h0000_0100);
        vmode = 1;
        run(200, 1'b0, cyc);
        chk("toggle_writes", wlog.size(), 4);
        if (wlog.size() == 4)
            for (int i = 0; i < 4; i++) chk("toggle_addr", wlog[i].addr, 'h100 + i);

        // Address wrap
        cfg_clear();
        cfg_set(3, 4, 'hFFFE, 32'hDEAD_BEEF);
        vmode = 2;
        run(200, 1'b0, cyc);
        w_addr = '{'hFFFE, 'hFFFF, 'h0000, 'h0001};
        chk("wrap_writes", wlog.size(), 4);
        if (wlog.size() == 4)
            for (int i = 0; i < 4; i++) chk("wrap_addr", wlog[i].addr, w_addr[i]);

        // Slow streamer acceptance
        cfg_clear();
        cfg_set(5, 2, 'h300, 32'hCAFE_0000);
        vmode = 0; rd_delay = 5; req_cycles = 0;
        run(200, 1'b0, cyc);
        chk("slow_req_cycles", req_cycles, 6);
        chk("slow_writes", wlog.size(), 2);
        rd_delay = 0;

        // Abort after two of five beats, then a clean run
        cfg_clear();
        cfg_set(2, 5, 'h40, 32'h0000_2000);
        vmode = 3; man_valid = 1'b0;
        wlog.delete();
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 100 && ready_o !== 1'b1; i++) @(negedge clk);
        chk("clear_ready_seen", ready_o, 1);
        @(posedge clk); man_valid = 1'b1;
        @(posedge clk);
        @(posedge clk); man_valid = 1'b0;
        #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        @(negedge clk);
        chk("clear_busy_next", busy_o, 0);
        repeat (10) @(posedge clk);
        chk("clear_writes", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("clear_addr0", wlog[0].addr, 'h40);
            chk("clear_addr1", wlog[1].addr, 'h41);
        end
        chk("clear_no_done", done_cnt - d0, 0);
        vmode = 0;
        cfg_clear();
        cfg_set(0, 3, 'h10, 32'h1000_0000);
        cfg_set(4, 2, 'h20, 32'h4000_0040);
        run(200, 1'b0, cyc);
        chk("after_clear_writes", wlog.size(), 5);

        // Reset in the middle of a stream
        cfg_clear();
        cfg_set(6, 10, 'h600, 32'h0000_6000);
        wlog.delete();
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 100 && wlog.size() < 3; i++) @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (10) @(posedge clk);
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_partial", wlog.size() < 10, 1);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            cfg_clear();
            exp_total = 0;
            for (int i = 0; i < NB; i++) begin
                cfg_en_i[i] = 1'($urandom_range(0, 1));
                cfg_len_i[i] = LW'($urandom_range(0, 12));
                cfg_amem_addr_i[i] = AW'($urandom);
                cfg_dmem_addr_i[i] = $urandom;
                if (cfg_en_i[i]) exp_total += int'(cfg_len_i[i]);
            end
            vmode = int'($urandom_range(0, 2));
            rd_delay = int'($urandom_range(0, 3));
            run(2000, 1'b1, cyc);
            chk("rand_write_total", wlog.size(), exp_total);
        end
        rd_delay = 0;

        // Maximum length
        cfg_clear();
        cfg_set(0, 65535, 'h1234, 32'h0BAD_F00D);
        vmode = 0;
        run(70000, 1'b0, cyc);
        chk("maxlen_writes", wlog.size(), 65535);
        if (wlog.size() == 65535) chk("maxlen_last_addr", wlog[65534].addr, 'h1232);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
